mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Sits beside the ALU. Its HI/LO outputs feed the write-data mux into the register file for mfhi/mflo.
- Executes mult/multu/div/divu over multiple cycles and holds the datapath through `busy`.
- Also services the HI/LO move-to writes (mthi/mtlo).

Parameters:
- N, 32, operand width; HI and LO are each N bits; an operation takes N iteration cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  launch the operation selected by op; sampled only in IDLE
- op  input  2  00 multu, 01 divu, 10 mult, 11 div
- a  input  N  rs operand (multiplicand / dividend); sampled on the start edge
- b  input  N  rt operand (multiplier / divisor); sampled on the start edge
- write_hi  input  1  mthi: load HI from write_data (IDLE only)
- write_lo  input  1  mtlo: load LO from write_data (IDLE only)
- write_data  input  N  data for mthi/mtlo
- hi  output  N  HI register (product upper half / remainder)
- lo  output  N  LO register (product lower half / quotient)
- busy  output  1  operation in progress; the datapath stalls while high
- done  output  1  one-cycle pulse: HI/LO were just updated by an operation
- div_zero  output  1  valid with done; the completed divide had b == 0

Behaviour:
- Reset (rst low, asynchronous, any state including mid-operation):
  - FSM returns to IDLE; the operation is aborted.
  - hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0; internal counters and accumulators cleared.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE, start = 1 at edge E0:
  - Latch a, b and op; load counter = N; busy = 1 after E0.
  - op[0] = 0 goes to MUL; op[0] = 1 goes to DIV.
  - Divide with b == 0 goes directly to FIN.
- MUL (radix-2 shift-add):
  - One iteration per edge, E1..EN; 2N-bit accumulator.
  - At EN: hi = product[2N-1:N], lo = product[N-1:0]; go to FIN.
- DIV (restoring division): one quotient bit per edge, E1..EN. At EN: lo = quotient, hi = remainder; go to FIN.
- Divide by zero:
  - At E1: hi = a, lo = all ones, div_zero = 1; go to FIN.
  - Total latency is 1 edge instead of N.
- FIN:
  - Entered on the edge that writes HI/LO; in FIN, done = 1 and busy = 0.
  - Next edge returns to IDLE, done = 0, div_zero = 0.
  - start is sampled in FIN exactly as in IDLE, so a back-to-back operation is allowed. mthi/mtlo behave as in IDLE.
- Latency: done is visible after edge EN (N edges after E0). busy is high from E0 to EN exclusive of FIN.
- start while busy: ignored; no queueing.
- write_hi / write_lo:
  - Honoured only in IDLE/FIN; ignored while busy.
  - Both may be asserted together.
  - start has priority: if start and a write coincide, the write is dropped.
- HI/LO hold their values at all other times; they are never partially updated during iteration.
- All arithmetic is modulo 2N (product) or N (quotient/remainder); no overflow flag.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: op[1] = 1 selects signed operation.
  - Operands are converted to magnitudes at E0 and the unsigned core runs unchanged; latency is identical.
  - The product is negated if the operand signs differ.
  - The quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - Signed divide by zero gives the same result as unsigned.
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- Undefined: op[1] is ignored and every operation is unsigned; no sign-fix logic is synthesised.

Test Plan:
- multu, a = 0xFFFFFFFF, b = 0xFFFFFFFF -> after 32 edges: hi = 0xFFFFFFFE, lo = 0x00000001; done pulses exactly 1 cycle; busy high for 32 cycles.
- divu, a = 100, b = 7 -> hi = 2, lo = 14, div_zero = 0. Then divu a = 5, b = 0 -> after 1 edge: hi = 5, lo = 0xFFFFFFFF, div_zero = 1.
- multu in flight, rst pulled low at cycle 10 -> hi = lo = 0, busy = 0 immediately (asynchronous). New start after rst high -> correct result.
- In IDLE: write_hi = 1 with 0x12345678 -> hi = 0x12345678, lo unchanged. While busy: write_lo with 0xAAAA -> lo unaffected; start asserted mid-operation is ignored.
- MULDIV_SIGNED_EN defined: mult a = -3 (0xFFFFFFFD), b = 4 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF4. div a = -7, b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- MULDIV_SIGNED_EN undefined: op = 10, a = 0xFFFFFFFD, b = 4 -> hi = 0x00000003, lo = 0xFFFFFFF4 (unsigned result).

Source files
------------

// File: rtl/mul_div_if.sv
// ============================================================================
// Module      : mul_div_if
// Description : Command/result bundle between the datapath and mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_div_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         write_hi;
    logic         write_lo;
    logic [N-1:0] write_data;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_zero;

    modport master (
        output start, op, a, b, write_hi, write_lo, write_data,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b, write_hi, write_lo, write_data,
        output hi, lo, busy, done, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative shift-add multiply / restoring divide with HI/LO.
//               Signed mult/div are built only when MULDIV_SIGNED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int N = 32
) (
    input  logic       clk,
    input  logic       rst,
    mul_div_if.slave   bus
);

    localparam int           CW       = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic           dz_q, dz_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           div_zero_q, div_zero_d;

    logic           w_launch;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic [N:0]     w_mul_sum;
    logic [2*N-1:0] w_mul_next;
    logic [N+1:0]   w_div_diff;
    logic           w_div_ok;
    logic [2*N-1:0] w_div_next;
    logic [2*N-1:0] w_prod_fix;
    logic [N-1:0]   w_quo_fix;
    logic [N-1:0]   w_rem_fix;

    assign w_launch = ((state_q == S_IDLE) || (state_q == S_FIN)) && bus.start;

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign w_mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    assign w_mul_next = {w_mul_sum, acc_q[N-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    assign w_div_diff = {1'b0, acc_q[2*N-1:N-1]} - {2'b00, opnd_q};
    assign w_div_ok   = ~w_div_diff[N+1];
    assign w_div_next = {(w_div_ok ? w_div_diff[N-1:0] : acc_q[2*N-2:N-1]),
                         acc_q[N-2:0], w_div_ok};

`ifdef MULDIV_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic neg_res_q;
    logic neg_rem_q;

    assign w_a_neg = bus.op[1] & bus.a[N-1];
    assign w_b_neg = bus.op[1] & bus.b[N-1];
    assign w_a_mag = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag = w_b_neg ? -bus.b : bus.b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (w_launch) begin
            neg_res_q <= w_a_neg ^ w_b_neg;
            neg_rem_q <= w_a_neg;
        end
    end

    assign w_prod_fix = neg_res_q ? -w_mul_next : w_mul_next;
    assign w_quo_fix  = neg_res_q ? -w_div_next[N-1:0] : w_div_next[N-1:0];
    assign w_rem_fix  = neg_rem_q ? -w_div_next[2*N-1:N] : w_div_next[2*N-1:N];
`else
    logic w_unused_sign;

    assign w_unused_sign = bus.op[1];
    assign w_a_mag       = bus.a;
    assign w_b_mag       = bus.b;
    assign w_prod_fix    = w_mul_next;
    assign w_quo_fix     = w_div_next[N-1:0];
    assign w_rem_fix     = w_div_next[2*N-1:N];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    cnt_d = CNT_LOAD;
                    dz_d  = bus.op[0] && (bus.b == '0);
                    if (bus.op[0]) begin
                        state_d = S_DIV;
                        opnd_d  = w_b_mag;
                        // Divide-by-zero pre-loads its fixed result for the next edge.
                        acc_d   = (bus.b == '0) ? {bus.a, {N{1'b1}}} : {{N{1'b0}}, w_a_mag};
                    end else begin
                        state_d = S_MUL;
                        opnd_d  = w_a_mag;
                        acc_d   = {{N{1'b0}}, w_b_mag};
                    end
                end else begin
                    if (bus.write_hi) hi_d = bus.write_data;
                    if (bus.write_lo) lo_d = bus.write_data;
                end
            end
            S_MUL: begin
                acc_d = w_mul_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    hi_d    = w_prod_fix[2*N-1:N];
                    lo_d    = w_prod_fix[N-1:0];
                    state_d = S_FIN;
                end
            end
            S_DIV: begin
                if (dz_q) begin
                    hi_d       = acc_q[2*N-1:N];
                    lo_d       = acc_q[N-1:0];
                    div_zero_d = 1'b1;
                    state_d    = S_FIN;
                end else begin
                    acc_d = w_div_next;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        hi_d    = w_rem_fix;
                        lo_d    = w_quo_fix;
                        state_d = S_FIN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.done     = (state_q == S_FIN);
    assign bus.div_zero = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Scoreboard bench for mul_div_unit (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;
    localparam int N = 32;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dz;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mul_div_if #(.N(N)) bus ();

    mul_div_unit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (rst && bus.done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: hi=%h lo=%h with empty scoreboard", bus.hi, bus.lo);
            end else begin
                mon_e = sb.pop_front();
                if (bus.hi !== mon_e.hi || bus.lo !== mon_e.lo || bus.div_zero !== mon_e.dz) begin
                    errors++;
                    $display("FAIL result_op%0d: got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=%b",
                             mon_e.id, bus.hi, bus.lo, bus.div_zero, mon_e.hi, mon_e.lo, mon_e.dz);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [N-1:0] ehi, input logic [N-1:0] elo, input logic edz);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.id = id;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Counts busy negedges until done; returns at the negedge where done is seen.
    task automatic wait_done(input int lat);
        int  busy_n = 0;
        bit  seen   = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            else if (bus.busy) busy_n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within 200 cycles, required one");
            sb.delete();
        end else begin
            chk("busy_cycles", N'(busy_n), N'(lat));
            chk("busy_in_fin", N'(bus.busy), '0);
        end
    endtask

    task automatic run_op(input int id, input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] ehi, input logic [N-1:0] elo, input logic edz, input int lat);
        push_exp(id, ehi, elo, edz);
        issue(op, a, b);
        wait_done(lat);
    endtask

    task automatic done_low;
        @(negedge clk);
        chk("done_pulse_width", N'(bus.done), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.write_hi = 1'b0; bus.write_lo = 1'b0; bus.write_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", bus.hi, '0);
        chk("rst_lo", bus.lo, '0);
        chk("rst_busy", N'(bus.busy), '0);
        chk("rst_done", N'(bus.done), '0);
        chk("rst_div_zero", N'(bus.div_zero), '0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32);
        done_low();
        run_op(2, 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
        run_op(3, 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1);
        done_low();
`ifdef MULDIV_SIGNED_EN
        run_op(4, 2'b10, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, 32);
        run_op(5, 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32);
        run_op(6, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32);
`else
        run_op(4, 2'b10, 32'hFFFFFFFD, 32'd4, 32'h00000003, 32'hFFFFFFF4, 1'b0, 32);
        run_op(5, 2'b11, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 1'b0, 32);
        run_op(6, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 32);
`endif
        run_op(7, 2'b00, 32'h00010001, 32'h00010001, 32'h00000001, 32'h00020001, 1'b0, 32);
        run_op(8, 2'b01, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 32);
        run_op(9, 2'b01, 32'd3, 32'd7, 32'd3, 32'd0, 1'b0, 32);
        done_low();

        // Move-to writes in IDLE
        @(posedge clk); #1;
        bus.write_hi = 1'b1; bus.write_data = 32'h12345678;
        @(posedge clk); #1 bus.write_hi = 1'b0;
        chk("mthi_hi", bus.hi, 32'h12345678);
        chk("mthi_lo_kept", bus.lo, 32'd0);
        bus.write_hi = 1'b1; bus.write_lo = 1'b1; bus.write_data = 32'hCAFEF00D;
        @(posedge clk); #1 bus.write_hi = 1'b0; bus.write_lo = 1'b0;
        chk("mthilo_hi", bus.hi, 32'hCAFEF00D);
        chk("mthilo_lo", bus.lo, 32'hCAFEF00D);

        // start has priority over a coincident write
        push_exp(10, 32'd0, 32'd6, 1'b0);
        bus.write_hi = 1'b1; bus.write_data = 32'h55555555;
        issue(2'b00, 32'd2, 32'd3);
        bus.write_hi = 1'b0;
        wait_done(32);
        done_low();

        // Writes and start ignored while busy
        push_exp(11, 32'd0, 32'd15, 1'b0);
        issue(2'b00, 32'd3, 32'd5);
        bus.write_lo = 1'b1; bus.write_data = 32'h0000AAAA;
        @(negedge clk);
        chk("lo_hold_busy", bus.lo, 32'd6);
        @(posedge clk); #1;
        bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd0; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0; bus.write_lo = 1'b0;
        wait_done(30);
        done_low();

        // Asynchronous reset mid-operation
        push_exp(12, 32'd0, 32'd0, 1'b0);
        issue(2'b00, 32'hFFFFFFFF, 32'd3);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        sb.delete();
        chk("arst_hi", bus.hi, '0);
        chk("arst_lo", bus.lo, '0);
        chk("arst_busy", N'(bus.busy), '0);
        chk("arst_done", N'(bus.done), '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(13, 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 32);
        done_low();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", N'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
